// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Hazard-unit bundle between the RV32I datapath and the
//                central pipeline controller. The datapath side (master)
//                reports hazard sources; the controller side (slave)
//                returns register enables, flushes and status counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard sources reported by the datapath
  logic [4:0]       rs1_de;
  logic [4:0]       rs2_de;
  logic             use_rs1_de;
  logic             use_rs2_de;
  logic [4:0]       rd_ex;
  logic             RuWr_ex;
  logic             load_ex;
  logic             NextPCSrc;
  logic             mem_busy;
  logic             halt_req;

  // Pipeline register controls and status
  logic             pc_en;
  logic             fd_en;
  logic             fd_flush;
  logic             dx_en;
  logic             dx_flush;
  logic             xm_en;
  logic             mw_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side
  modport master (
    output rs1_de, rs2_de, use_rs1_de, use_rs2_de, rd_ex, RuWr_ex, load_ex,
           NextPCSrc, mem_busy, halt_req,
    input  pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halted,
           stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  rs1_de, rs2_de, use_rs1_de, use_rs2_de, rd_ex, RuWr_ex, load_ex,
           NextPCSrc, mem_busy, halt_req,
    output pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halted,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush controller for the 5-stage RV32I core.
//                Resolves memory freezes, branch redirects and load-use
//                stalls, sequences halt/drain/resume, and keeps saturating
//                stall and redirect event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    c_drain_load = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0]    c_drain_one  = DW'(1);
  localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [DW-1:0]     r_drain_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_rs1_hit;
  logic              w_rs2_hit;
  logic              w_load_use;
  logic              w_freeze;
  logic              w_redirect;

  logic              w_pc_en;
  logic              w_fd_en;
  logic              w_fd_flush;
  logic              w_dx_en;
  logic              w_dx_flush;
  logic              w_xm_en;
  logic              w_mw_en;
  logic              w_halted;

  // A load writing x0 never creates a dependency, so rd_ex==0 is excluded.
  assign w_rs1_hit  = bus.use_rs1_de & (bus.rs1_de == bus.rd_ex);
  assign w_rs2_hit  = bus.use_rs2_de & (bus.rs2_de == bus.rd_ex);
  assign w_load_use = bus.load_ex & bus.RuWr_ex & (bus.rd_ex != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);
  assign w_freeze   = bus.mem_busy;
  assign w_redirect = bus.NextPCSrc;

  // Strobe decode: freeze > redirect > load-use > normal; everything low in reset/halt.
  always_comb begin
    w_pc_en    = 1'b0;
    w_fd_en    = 1'b0;
    w_fd_flush = 1'b0;
    w_dx_en    = 1'b0;
    w_dx_flush = 1'b0;
    w_xm_en    = 1'b0;
    w_mw_en    = 1'b0;
    w_halted   = rst_n & (r_state == ST_HALTED);
    if (rst_n && !w_freeze && (r_state != ST_HALTED)) begin
      w_dx_en = 1'b1;
      w_xm_en = 1'b1;
      w_mw_en = 1'b1;
      if (w_redirect) begin
        // DE holds a wrong-path instruction, so any load-use on it is moot.
        w_pc_en    = 1'b1;
        w_fd_en    = 1'b1;
        w_fd_flush = 1'b1;
        w_dx_flush = 1'b1;
      end else if (w_load_use) begin
        w_dx_flush = 1'b1;
      end else if (r_state == ST_DRAIN) begin
        // PC holds so the flushed FE instruction is refetched on resume.
        w_fd_en    = 1'b1;
        w_fd_flush = 1'b1;
      end else begin
        w_pc_en = 1'b1;
        w_fd_en = 1'b1;
      end
    end
  end

  assign bus.pc_en     = w_pc_en;
  assign bus.fd_en     = w_fd_en;
  assign bus.fd_flush  = w_fd_flush;
  assign bus.dx_en     = w_dx_en;
  assign bus.dx_flush  = w_dx_flush;
  assign bus.xm_en     = w_xm_en;
  assign bus.mw_en     = w_mw_en;
  assign bus.halted    = w_halted;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // Halt/drain sequencing and saturating event counters; frozen while mem_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!w_freeze) begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            if (r_flush_cnt != c_cnt_max) r_flush_cnt <= r_flush_cnt + c_cnt_one;
          end else if (w_load_use) begin
            if (r_stall_cnt != c_cnt_max) r_stall_cnt <= r_stall_cnt + c_cnt_one;
          end
          if (bus.halt_req) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= c_drain_load;
          end
        end
        ST_DRAIN: begin
          if (w_redirect) begin
            // Fresh wrong-path work was squashed; the tail must drain again.
            if (r_flush_cnt != c_cnt_max) r_flush_cnt <= r_flush_cnt + c_cnt_one;
            r_drain_cnt <= c_drain_load;
          end else if (w_load_use) begin
            if (r_stall_cnt != c_cnt_max) r_stall_cnt <= r_stall_cnt + c_cnt_one;
          end else if (r_drain_cnt == c_drain_one) begin
            r_state     <= ST_HALTED;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt - c_drain_one;
          end
        end
        ST_HALTED: begin
          if (!bus.halt_req) r_state <= ST_RUN;
        end
        default: begin
          r_state     <= ST_RUN;
          r_drain_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32I core (FE/DE/EX/ME/WB).
- Generates enable and flush strobes for the PC, fetch/decode, decode/execute, execute/memory and memory/writeback registers.
- Handles load-use stalls, taken-branch redirects, data-memory wait states and an external halt/drain/resume sequence.
- Keeps saturating stall and flush event counters.

Parameters:
- DRAIN_CYCLES, 4, non-frozen, non-stalled cycles needed after halt entry to empty DE..WB.
- CNT_W, 32, width of the performance counters.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- rs1_de in 5: rs1 field of the instruction in DE.
- rs2_de in 5: rs2 field of the instruction in DE.
- use_rs1_de in 1: DE instruction reads rs1.
- use_rs2_de in 1: DE instruction reads rs2.
- rd_ex in 5: destination register of the instruction in EX.
- RuWr_ex in 1: EX instruction writes the register file.
- load_ex in 1: EX instruction is a load (RUDataWrSrc_ex selects memory data).
- NextPCSrc in 1: taken branch or jump resolved in EX.
- mem_busy in 1: data memory not ready; ME result invalid this cycle.
- halt_req in 1: level request to halt fetch and drain the pipeline.
- pc_en out 1: PC register load enable.
- fd_en out 1: FE/DE register enable (pcInc_de, pc_de, inst_de).
- fd_flush out 1: FE/DE register loads a NOP on the next edge. Only effective when fd_en=1.
- dx_en out 1: DE/EX register enable.
- dx_flush out 1: DE/EX register loads a bubble (RuWr=0, DMWr=0, BrOp=no-branch) on the next edge.
- xm_en out 1: EX/ME register enable.
- mw_en out 1: ME/WB register enable.
- halted out 1: pipeline is empty and held.
- stall_cnt out CNT_W: count of load-use stall cycles.
- flush_cnt out CNT_W: count of branch redirects.

Behaviour:
- Registered state: fsm ∈ {RUN, DRAIN, HALTED}, drain_cnt, stall_cnt, flush_cnt.
- All strobes and halted are combinational from the registered state and the current inputs.
- While rst_n=0: fsm=RUN, drain_cnt=0, counters=0, every enable 0, every flush 0, halted 0.
- After reset release with idle inputs, all enables read 1 and all flushes 0.
- load_use = load_ex & RuWr_ex & (rd_ex≠0) & ((use_rs1_de & rs1_de==rd_ex) | (use_rs2_de & rs2_de==rd_ex)).
- Strobe priority, highest first:
  1. freeze: mem_busy=1. All enables 0, flushes 0, no state or counter update. This applies in every state.
  2. redirect: NextPCSrc=1. All enables 1, fd_flush=1, dx_flush=1, flush_cnt+1. This applies in RUN and DRAIN. Redirect overrides load_use, because the DE instruction is wrong-path.
  3. load_use (RUN or DRAIN). pc_en=0, fd_en=0, dx_en=1 with dx_flush=1, xm_en=mw_en=1, stall_cnt+1. The penalty is exactly 1 cycle, since load_ex clears once the bubble enters EX.
  4. normal. RUN: all enables 1, flushes 0. DRAIN: pc_en=0, fd_en=1, fd_flush=1, other enables 1.
- FSM transitions (all evaluated only when mem_busy=0):
  - RUN→DRAIN when halt_req=1; drain_cnt ← DRAIN_CYCLES. In the entry cycle the normal RUN rules still apply. The instruction in FE is flushed on the first DRAIN cycle, and PC keeps its address so it is refetched on resume.
  - DRAIN: drain_cnt decrements only in normal (non-stall, non-redirect) cycles. A redirect reloads drain_cnt ← DRAIN_CYCLES.
  - DRAIN→HALTED when drain_cnt==1 and decrementing. DRAIN always completes even if halt_req drops.
  - HALTED: all enables 0, flushes 0, halted=1. Moves to RUN on the cycle after halt_req=0 is sampled.
  - In HALTED, halt_req=1 holds the state.
- Counters saturate at all-ones; no wrap.
- Asynchronous reset mid-DRAIN or mid-HALTED returns immediately to RUN with counters cleared.
- mem_busy held for N cycles extends any state by exactly N cycles.

Test Plan:
1. Reset, then idle RUN. rst_n=0 → all enables 0. Release with idle inputs → pc_en=fd_en=dx_en=xm_en=mw_en=1, flushes 0, halted=0, counters 0.
2. Load-use. load_ex=1, RuWr_ex=1, rd_ex=5, rs2_de=5, use_rs2_de=1 for one cycle → pc_en=0, fd_en=0, dx_flush=1, stall_cnt=1. Repeat with rd_ex=0 → no stall.
3. Redirect vs load-use. NextPCSrc=1 together with a load_use condition → pc_en=1, fd_flush=1, dx_flush=1, flush_cnt=1, stall_cnt unchanged.
4. Freeze. mem_busy=1 for 3 cycles during a load_use → all enables 0 for 3 cycles, then the stall is applied once and stall_cnt=1.
5. Halt. halt_req=1 in RUN, no hazards → 4 DRAIN cycles with pc_en=0 and fd_flush=1, then halted=1. Drop halt_req → RUN one cycle later with pc_en=1.
6. Drain with redirect. NextPCSrc=1 on the 2nd DRAIN cycle → pc_en=1 and drain_cnt reloaded; halted asserts 4 normal cycles later. Assert rst_n=0 mid-DRAIN → back to RUN, counters 0.
